// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester round-robin arbiter in front of a single-port word memory.
// Runs one transaction at a time as IDLE -> ACCESS -> RESP, so a new access
// can start at most once every three cycles.
//
//   IDLE   : a valid requester is granted through a combinational ready. The
//            request fields and the owner ID are latched on the handshake edge.
//   ACCESS : registered mem_cs/mem_we/address/wdata drive the memory. The
//            memory updates mem_rdata on the falling edge. That value is
//            captured into rsp_rdata at the end of the cycle (reads only).
//   RESP   : the owner gets a one-cycle rsp_valid pulse. There is no
//            back-pressure.
//
// Optional feature (macro MEM_ARB_ADDR_CHECK_EN):
//   A request is flagged bad when addr[1:0] != 0 or addr > 2^ADDR_W-4. A bad
//   request is still accepted but never touches the memory. Its response
//   returns rsp_err=1 and rsp_rdata=0. With the macro undefined, every
//   request reaches memory and rsp_err is tied to 0.
//
// Parameters
//   ADDR_W  byte-address width (default 7)
//   DATA_W  memory word width  (default 32)
//
// Ports
//   CLK, RST                   clock; synchronous active-high reset
//   m0_req_valid/m1_req_valid  requester has a pending access
//   m0_req_ready/m1_req_ready  arbiter accepts that requester this cycle
//   m0_req_we/m1_req_we        1 = write, 0 = read
//   m0_req_addr/m1_req_addr    byte address, forwarded unmodified
//   m0_req_wdata/m1_req_wdata  write data
//   m0_rsp_valid/m1_rsp_valid  one-cycle completion pulse
//   rsp_rdata                  read data, valid with an rsp_valid for a read
//   rsp_err                    error flag, qualified by rsp_valid
//   mem_cs, mem_we             memory chip select / write enable
//   mem_waddr, mem_raddr       memory write / read address
//   mem_wdata                  memory write data
//   mem_rdata                  memory read data (updated on falling CLK)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // requester 0
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_rsp_valid,
  // requester 1
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_rsp_valid,
  // shared response
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // memory side
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // last_served: 0 = m0 was granted last, 1 = m1 was granted last.
  // Resetting it to 1 makes m0 win the first tie.
  logic last_served;
  logic owner;          // requester of the transaction in flight
  logic lat_we;         // latched request direction (independent of addr check)
  logic req_bad;        // latched address-check result
  logic addr_bad;       // address-check result for the request being granted

  logic              grant_m1;
  logic              handshake;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // ---------------------------------------------------------------------------
  // Grant selection and request mux
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_m1  = 1'b0;
    sel_we    = m0_req_we;
    sel_addr  = m0_req_addr;
    sel_wdata = m0_req_wdata;

    if (m0_req_valid && m1_req_valid) begin
      grant_m1 = ~last_served;          // the one not served last wins a tie
    end else begin
      grant_m1 = m1_req_valid;
    end

    if (grant_m1) begin
      sel_we    = m1_req_we;
      sel_addr  = m1_req_addr;
      sel_wdata = m1_req_wdata;
    end
  end

  // Ready only in IDLE and never while RST is high, so reset wins over a
  // simultaneous handshake. grant_m1 makes the two readies mutually exclusive.
  assign m0_req_ready = (state == IDLE) && !RST && m0_req_valid && !grant_m1;
  assign m1_req_ready = (state == IDLE) && !RST && m1_req_valid &&  grant_m1;
  assign handshake    = m0_req_ready || m1_req_ready;

  // Response pulse comes from the state. Gating with RST keeps an abort
  // during RESP from producing a completion.
  assign m0_rsp_valid = (state == RESP) && !RST && (owner == 1'b0);
  assign m1_rsp_valid = (state == RESP) && !RST && (owner == 1'b1);

  // ---------------------------------------------------------------------------
  // Optional address check
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam int unsigned ADDR_MAX = (2 ** ADDR_W) - 4;

  assign addr_bad = (sel_addr[1:0] != 2'b00) || (32'(sel_addr) > ADDR_MAX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_bad <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (handshake) begin
        req_bad <= addr_bad;
      end
      if (state == ACCESS) begin
        rsp_err <= req_bad;
      end
    end
  end
`else
  assign addr_bad = 1'b0;
  assign req_bad  = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from pre-edge values, whatever the order of the blocks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (handshake) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch, memory drive, read capture
  // ---------------------------------------------------------------------------
  // mem_cs/mem_we are set on the handshake edge, so they are high exactly
  // during ACCESS. Addresses and wdata keep their last values afterwards.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_served <= 1'b1;
      owner       <= 1'b0;
      lat_we      <= 1'b0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_raddr   <= '0;
      mem_wdata   <= '0;
      rsp_rdata   <= '0;
    end else begin
      if (handshake) begin
        owner       <= grant_m1;
        last_served <= grant_m1;
        lat_we      <= sel_we;
        mem_cs      <= !addr_bad;
        mem_we      <= sel_we && !addr_bad;
        mem_waddr   <= sel_addr;
        mem_raddr   <= sel_addr;
        mem_wdata   <= sel_wdata;
      end else if (state == ACCESS) begin
        mem_cs <= 1'b0;
        mem_we <= 1'b0;
        if (req_bad) begin
          rsp_rdata <= '0;
        end else if (!lat_we) begin
          rsp_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed self-checking bench for mem_arbiter. A little-endian byte memory
// model (byte i initialised to i) answers reads on the falling clock and
// applies writes on the rising clock. Inputs are driven 1 time unit after
// the rising edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
  logic [ADDR_W-1:0] m0_req_addr;
  logic [DATA_W-1:0] m0_req_wdata;
  logic              m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
  logic [ADDR_W-1:0] m1_req_addr;
  logic [DATA_W-1:0] m1_req_wdata;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_req_we    (m0_req_we),
    .m0_req_addr  (m0_req_addr),
    .m0_req_wdata (m0_req_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_req_we    (m1_req_we),
    .m1_req_addr  (m1_req_addr),
    .m1_req_wdata (m1_req_wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_cs       (mem_cs),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_raddr    (mem_raddr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Byte memory model
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:127];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
  end

  always @(negedge CLK) begin
    logic [6:0] a;
    a = mem_raddr;
    mem_rdata = {mem[7'(a + 7'd3)], mem[7'(a + 7'd2)], mem[7'(a + 7'd1)], mem[a]};
  end

  always @(posedge CLK) begin
    logic [6:0] a;
    if (mem_cs && mem_we) begin
      a = mem_waddr;
      for (int k = 0; k < 4; k++) mem[7'(a + 7'(k))] = mem_wdata[8*k +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // One complete transaction, starting just after a rising edge with the
  // arbiter in IDLE. exp_rdata is the value rsp_rdata must show in RESP
  // (the held value for a write).
  task automatic xfer(input bit port, input bit we, input logic [6:0] addr,
                      input logic [31:0] wdata, input bit exp_cs,
                      input bit exp_err, input logic [31:0] exp_rdata);
    if (port == 1'b0) begin
      m0_req_valid = 1'b1; m0_req_we = we; m0_req_addr = addr; m0_req_wdata = wdata;
    end else begin
      m1_req_valid = 1'b1; m1_req_we = we; m1_req_addr = addr; m1_req_wdata = wdata;
    end
    @(negedge CLK);                                    // cycle N
    check("ready_m0_N", 32'(m0_req_ready), 32'(port == 1'b0));
    check("ready_m1_N", 32'(m1_req_ready), 32'(port == 1'b1));
    next_cycle();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    @(negedge CLK);                                    // cycle N+1
    check("access_cs",    32'(mem_cs), 32'(exp_cs));
    check("access_we",    32'(mem_we), 32'(we && exp_cs));
    check("access_raddr", 32'(mem_raddr), 32'(addr));
    check("access_waddr", 32'(mem_waddr), 32'(addr));
    if (we) check("access_wdata", mem_wdata, wdata);
    check("access_no_ready", 32'({m0_req_ready, m1_req_ready}), 32'd0);
    next_cycle();
    @(negedge CLK);                                    // cycle N+2
    check("resp_m0_valid", 32'(m0_rsp_valid), 32'(port == 1'b0));
    check("resp_m1_valid", 32'(m1_rsp_valid), 32'(port == 1'b1));
    check("resp_cs",       32'(mem_cs), 32'd0);
    check("resp_err",      32'(rsp_err), 32'(exp_err));
    check("resp_rdata",    rsp_rdata, exp_rdata);
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    RST = 1'b1;
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 7'h04; m0_req_wdata = '0;
    m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = '0;    m1_req_wdata = '0;

    // Reset state; a valid request during reset is not accepted.
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check("rst_ready_m0", 32'(m0_req_ready), 32'd0);
    check("rst_rsp",      32'({m0_rsp_valid, m1_rsp_valid}), 32'd0);
    check("rst_cs_we",    32'({mem_cs, mem_we}), 32'd0);
    check("rst_addr",     32'({mem_waddr, mem_raddr}), 32'd0);
    check("rst_wdata",    mem_wdata, 32'd0);
    check("rst_rdata",    rsp_rdata, 32'd0);
    check("rst_err",      32'(rsp_err), 32'd0);
    next_cycle();
    RST = 1'b0;
    m0_req_valid = 1'b0;

    // Basic read by m0, write by m1 (rsp_rdata holds), read-back by m0.
    xfer(1'b0, 1'b0, 7'h04, 32'h0,        1'b1, 1'b0, 32'h07060504);
    xfer(1'b1, 1'b1, 7'h08, 32'hDEADBEEF, 1'b1, 1'b0, 32'h07060504);
    xfer(1'b0, 1'b0, 7'h08, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF);

    // Round robin with both requesters continuously valid after reset.
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 7'h10;
    m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = 7'h14;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("rr_ready_m0", 32'(m0_req_ready), 32'(k % 2 == 0));
      check("rr_ready_m1", 32'(m1_req_ready), 32'(k % 2 == 1));
      next_cycle();
      @(negedge CLK);
      check("rr_access_no_ready", 32'({m0_req_ready, m1_req_ready}), 32'd0);
      next_cycle();
      @(negedge CLK);
      check("rr_rsp_m0", 32'(m0_rsp_valid), 32'(k % 2 == 0));
      check("rr_rsp_m1", 32'(m1_rsp_valid), 32'(k % 2 == 1));
      check("rr_rdata",  rsp_rdata, (k % 2 == 0) ? 32'h13121110 : 32'h17161514);
      next_cycle();
    end
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;

    // Reset during ACCESS aborts the m0 read.
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 7'h04;
    @(negedge CLK);
    check("abort_ready", 32'(m0_req_ready), 32'd1);
    next_cycle();
    m0_req_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("abort_access_cs", 32'(mem_cs), 32'd1);
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    check("abort_cs_after",  32'(mem_cs), 32'd0);
    check("abort_no_rsp",    32'({m0_rsp_valid, m1_rsp_valid}), 32'd0);
    next_cycle();
    @(negedge CLK);
    check("abort_no_rsp2",   32'({m0_rsp_valid, m1_rsp_valid}), 32'd0);
    next_cycle();
    xfer(1'b1, 1'b0, 7'h20, 32'h0, 1'b1, 1'b0, 32'h23222120);

    // Top aligned address is legal in both builds; 0x7E is flagged only
    // when the address check is compiled in.
    xfer(1'b0, 1'b0, 7'h7C, 32'h0, 1'b1, 1'b0, 32'h7F7E7D7C);
`ifdef MEM_ARB_ADDR_CHECK_EN
    xfer(1'b0, 1'b0, 7'h7E, 32'h0, 1'b0, 1'b1, 32'h00000000);
`else
    xfer(1'b0, 1'b0, 7'h7E, 32'h0, 1'b1, 1'b0, 32'h01007F7E);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
